// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU behind an enable/done handshake: single-cycle ADD/SUB,
// eight-iteration shift-add MUL and restoring DIV, with a one-cycle done pulse.
`timescale 1ns/1ps

module alu_exec_unit #(
  parameter int WIDTH = 16,
  parameter int OP_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [3:0]       opcode,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             div_by_zero,
  output logic             err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;

  localparam logic [2:0] LAST_ITER = 3'd7;

  logic [1:0]        state_q, state_d;
  logic [3:0]        opcode_q, opcode_d;
  logic [OP_W-1:0]   a_q, a_d;
  logic [OP_W-1:0]   b_q, b_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2*OP_W-1:0] prod_q, prod_d;
  logic [OP_W-1:0]   rem_q, rem_d;
  logic [OP_W-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              err_q, err_d;
  logic              dbz_q, dbz_d;

  logic [OP_W:0]     sum;
  logic [OP_W:0]     diff;
  logic [OP_W:0]     trial;
  logic [2*OP_W-1:0] partial;
  logic [2*OP_W-1:0] prod_next;
  logic [OP_W-1:0]   rem_next;
  logic [OP_W-1:0]   quo_next;

  // One iteration of each arithmetic step, evaluated from the latched operands.
  always_comb begin
    sum       = {1'b0, a_q} + {1'b0, b_q};
    diff      = {1'b0, a_q} - {1'b0, b_q};
    partial   = b_q[cnt_q] ? ({{OP_W{1'b0}}, a_q} << cnt_q) : '0;
    prod_next = prod_q + partial;
    // Restoring division brings in dividend bits MSB first.
    trial     = {rem_q, a_q[LAST_ITER - cnt_q]};
    if (trial >= {1'b0, b_q}) begin
      rem_next = OP_W'(trial - {1'b0, b_q});
      quo_next = {quo_q[OP_W-2:0], 1'b1};
    end else begin
      rem_next = trial[OP_W-1:0];
      quo_next = {quo_q[OP_W-2:0], 1'b0};
    end
  end

  always_comb begin
    // NOTE: every next-state signal defaults to its current value first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    state_d  = state_q;
    opcode_d = opcode_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
    err_d    = err_q;
    dbz_d    = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d  = S_CALC;
          opcode_d = opcode;
          a_d      = a;
          b_d      = b;
          cnt_d    = '0;
          prod_d   = '0;
          rem_d    = '0;
          quo_d    = '0;
          result_d = '0;
          err_d    = 1'b0;
          dbz_d    = 1'b0;
        end
      end

      S_CALC: begin
        case (opcode_q)
          OP_ADD: begin
            result_d = {{(WIDTH-OP_W-1){1'b0}}, sum};
            state_d  = S_DONE;
          end
          OP_SUB: begin
            result_d = {{(WIDTH-OP_W-1){diff[OP_W]}}, diff};
            state_d  = S_DONE;
          end
          OP_MUL: begin
            prod_d = prod_next;
            cnt_d  = cnt_q + 3'd1;
            if (cnt_q == LAST_ITER) begin
              result_d = WIDTH'(prod_next);
              state_d  = S_DONE;
            end
          end
          OP_DIV: begin
            if (b_q == '0) begin
              result_d = WIDTH'({a_q, {OP_W{1'b1}}});
              dbz_d    = 1'b1;
              state_d  = S_DONE;
            end else begin
              rem_d = rem_next;
              quo_d = quo_next;
              cnt_d = cnt_q + 3'd1;
              if (cnt_q == LAST_ITER) begin
                result_d = WIDTH'({rem_next, quo_next});
                state_d  = S_DONE;
              end
            end
          end
          default: begin
            result_d = '0;
            err_d    = 1'b1;
            state_d  = S_DONE;
          end
        endcase
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand and scratch registers are cleared on reset as well, so the unit
  // comes up in a fully known state rather than only a known FSM state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the old
      // values of the others, matching real flip-flop behaviour at the edge.
      state_q  <= state_d;
      opcode_q <= opcode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      err_q    <= err_d;
      dbz_q    <= dbz_d;
    end
  end

  assign done        = (state_q == S_DONE);
  assign busy        = (state_q == S_CALC);
  assign result      = result_q;
  assign err         = err_q;
  assign div_by_zero = dbz_q;

endmodule
